cpu_controller: RTL

//  Instruction register, decoder and control FSM placed directly upstream of the datapath.

---
 rtl/cpu_pkg.sv | 58 +++++
 rtl/cpu_controller_if.sv | 50 +++++
 rtl/instr_decoder.sv | 30 +++
 rtl/cpu_controller.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared state encodings, field widths, opcode/ALU/vsel constants and control payload
// for the cpu_controller instruction sequencer.
package cpu_pkg;

  localparam int unsigned OPC_W  = 3;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned SH_W   = 2;
  localparam int unsigned VSEL_W = 4;

  localparam logic [OPC_W-1:0] OPC_MOV = OPC_W'(3'b110);
  localparam logic [OPC_W-1:0] OPC_ALU = OPC_W'(3'b101);

  localparam logic [OP_W-1:0] OP_MOV_IMM = OP_W'(2'b10);
  localparam logic [OP_W-1:0] OP_MOV_REG = OP_W'(2'b00);

  localparam logic [OP_W-1:0] ALU_ADD = OP_W'(2'b00);
  localparam logic [OP_W-1:0] ALU_CMP = OP_W'(2'b01);
  localparam logic [OP_W-1:0] ALU_AND = OP_W'(2'b10);
  localparam logic [OP_W-1:0] ALU_MVN = OP_W'(2'b11);

  localparam logic [VSEL_W-1:0] VSEL_MDATA = VSEL_W'(4'b1000);
  localparam logic [VSEL_W-1:0] VSEL_IMM8  = VSEL_W'(4'b0100);
  localparam logic [VSEL_W-1:0] VSEL_PC    = VSEL_W'(4'b0010);
  localparam logic [VSEL_W-1:0] VSEL_C     = VSEL_W'(4'b0001);

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_WIMM   = 3'd2,
    S_GETA   = 3'd3,
    S_GETB   = 3'd4,
    S_EXEC   = 3'd5,
    S_WREG   = 3'd6
  } state_e;

  // Datapath control bundle, registered as a unit in the controller
  typedef struct packed {
    logic [REG_W-1:0]  readnum;
    logic [REG_W-1:0]  writenum;
    logic              write;
    logic [VSEL_W-1:0] vsel;
    logic              loada;
    logic              loadb;
    logic              loadc;
    logic              loads;
    logic              asel;
    logic              bsel;
    logic [SH_W-1:0]   shift;
    logic [OP_W-1:0]   aluop;
  } ctrl_t;

  function automatic logic is_legal(input logic [OPC_W-1:0] opcode, input logic [OP_W-1:0] op);
    return ((opcode == OPC_MOV) && ((op == OP_MOV_IMM) || (op == OP_MOV_REG))) ||
           (opcode == OPC_ALU);
  endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Instruction handshake and datapath control bundle between the controller and its neighbours.
// The err signal exists only when CPU_CTRL_ILLEGAL_TRAP_EN is defined.
interface cpu_controller_if
  import cpu_pkg::*;
#(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned DATA_W  = 16
) ();

  logic                instr_valid;
  logic [INSTR_W-1:0]  instr;
  logic                instr_ready;
  logic                done;
  logic [REG_W-1:0]    readnum;
  logic [REG_W-1:0]    writenum;
  logic                write;
  logic [VSEL_W-1:0]   vsel;
  logic                loada;
  logic                loadb;
  logic                loadc;
  logic                loads;
  logic                asel;
  logic                bsel;
  logic [SH_W-1:0]     shift;
  logic [OP_W-1:0]     ALUop;
  logic [DATA_W-1:0]   sximm8;
  logic [DATA_W-1:0]   sximm5;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  logic                err;
`endif

  modport master (
    output instr_valid, instr,
    input  instr_ready, done, readnum, writenum, write, vsel,
           loada, loadb, loadc, loads, asel, bsel, shift, ALUop, sximm8, sximm5
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    , input err
`endif
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, done, readnum, writenum, write, vsel,
           loada, loadb, loadc, loads, asel, bsel, shift, ALUop, sximm8, sximm5
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    , output err
`endif
  );

endinterface

// File: rtl/instr_decoder.sv
// Combinational field extraction and immediate sign-extension for one instruction word.
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned DATA_W  = 16
) (
  input  logic [INSTR_W-1:0] ir_i,
  output logic [OPC_W-1:0]   opcode_c_o,
  output logic [OP_W-1:0]    op_c_o,
  output logic [REG_W-1:0]   rn_c_o,
  output logic [REG_W-1:0]   rd_c_o,
  output logic [SH_W-1:0]    sh_c_o,
  output logic [REG_W-1:0]   rm_c_o,
  output logic [DATA_W-1:0]  sximm8_c_o,
  output logic [DATA_W-1:0]  sximm5_c_o
);

  assign opcode_c_o = ir_i[15:13];
  assign op_c_o     = ir_i[12:11];
  assign rn_c_o     = ir_i[10:8];
  assign rd_c_o     = ir_i[7:5];
  assign sh_c_o     = ir_i[4:3];
  assign rm_c_o     = ir_i[2:0];

  // Signed size casts replicate the immediate's top bit into the upper bits
  assign sximm8_c_o = DATA_W'($signed(ir_i[7:0]));
  assign sximm5_c_o = DATA_W'($signed(ir_i[4:0]));

endmodule

// File: rtl/cpu_controller.sv
// Instruction register, decoder and control FSM driving the datapath; one instruction per handshake.
// Define CPU_CTRL_ILLEGAL_TRAP_EN to latch a sticky err flag and stall on illegal instructions.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned DATA_W  = 16
) (
  input logic             clk,
  input logic             reset,
  cpu_controller_if.slave bus
);

  state_e              state_q, state_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  ctrl_t               ctrl_q, ctrl_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   sximm8_q, sximm5_q;
  logic [DATA_W-1:0]   sximm8_c, sximm5_c;
  logic                accept_c;
  logic                trap_block_c;
  logic                is_cmp_c;
  logic                is_movr_c;

  logic [OPC_W-1:0]    opcode_c;
  logic [OP_W-1:0]     op_c;
  logic [REG_W-1:0]    rn_c, rd_c, rm_c;
  logic [SH_W-1:0]     sh_c;

  assign accept_c = bus.instr_valid && ready_q;

  always_comb begin
    ir_d = ir_q;
    if (accept_c) begin
      ir_d = bus.instr;
    end
  end

  // Decodes the IR value that will be current after this edge, so registered outputs match it
  instr_decoder #(
    .INSTR_W (INSTR_W),
    .DATA_W  (DATA_W)
  ) u_instr_decoder (
    .ir_i       (ir_d),
    .opcode_c_o (opcode_c),
    .op_c_o     (op_c),
    .rn_c_o     (rn_c),
    .rd_c_o     (rd_c),
    .sh_c_o     (sh_c),
    .rm_c_o     (rm_c),
    .sximm8_c_o (sximm8_c),
    .sximm5_c_o (sximm5_c)
  );

  assign is_cmp_c  = (opcode_c == OPC_ALU) && (op_c == ALU_CMP);
  assign is_movr_c = (opcode_c == OPC_MOV);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT: begin
        if (accept_c) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_WAIT;
        if ((opcode_c == OPC_MOV) && (op_c == OP_MOV_IMM)) begin
          state_d = S_WIMM;
        end else if ((opcode_c == OPC_MOV) && (op_c == OP_MOV_REG)) begin
          state_d = S_GETB;
        end else if ((opcode_c == OPC_ALU) && (op_c == ALU_MVN)) begin
          state_d = S_GETB;
        end else if (opcode_c == OPC_ALU) begin
          state_d = S_GETA;
        end
      end
      S_WIMM:  state_d = S_WAIT;
      S_GETA:  state_d = S_GETB;
      S_GETB:  state_d = S_EXEC;
      S_EXEC:  state_d = is_cmp_c ? S_WAIT : S_WREG;
      S_WREG:  state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase
  end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  logic err_q, err_d;

  // Sticky until reset; latched on the DECODE cycle of an illegal word
  always_comb begin
    err_d = err_q;
    if ((state_q == S_DECODE) && !is_legal(opcode_c, op_c)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign trap_block_c = err_d;
  assign bus.err      = err_q;
`else
  assign trap_block_c = 1'b0;
`endif

  // Moore controls evaluated for the state and IR that will hold after this edge
  always_comb begin
    ctrl_d  = '0;
    ready_d = (state_d == S_WAIT) && !trap_block_c;
    done_d  = (state_d == S_WAIT) && (state_q != S_WAIT);
    case (state_d)
      S_WIMM: begin
        ctrl_d.writenum = rn_c;
        ctrl_d.vsel     = VSEL_IMM8;
        ctrl_d.write    = 1'b1;
      end
      S_GETA: begin
        ctrl_d.readnum = rn_c;
        ctrl_d.loada   = 1'b1;
      end
      S_GETB: begin
        ctrl_d.readnum = rm_c;
        ctrl_d.loadb   = 1'b1;
      end
      S_EXEC: begin
        ctrl_d.shift = sh_c;
        ctrl_d.aluop = is_movr_c ? ALU_ADD : op_c;
        ctrl_d.loadc = !is_cmp_c;
        ctrl_d.loads = is_cmp_c;
        ctrl_d.asel  = is_movr_c;
        ctrl_d.bsel  = 1'b0;
      end
      S_WREG: begin
        ctrl_d.writenum = rd_c;
        ctrl_d.vsel     = VSEL_C;
        ctrl_d.write    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_WAIT;
      ir_q     <= '0;
      ctrl_q   <= '0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      sximm8_q <= '0;
      sximm5_q <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      ctrl_q   <= ctrl_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      sximm8_q <= sximm8_c;
      sximm5_q <= sximm5_c;
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.done        = done_q;
  assign bus.readnum     = ctrl_q.readnum;
  assign bus.writenum    = ctrl_q.writenum;
  assign bus.write       = ctrl_q.write;
  assign bus.vsel        = ctrl_q.vsel;
  assign bus.loada       = ctrl_q.loada;
  assign bus.loadb       = ctrl_q.loadb;
  assign bus.loadc       = ctrl_q.loadc;
  assign bus.loads       = ctrl_q.loads;
  assign bus.asel        = ctrl_q.asel;
  assign bus.bsel        = ctrl_q.bsel;
  assign bus.shift       = ctrl_q.shift;
  assign bus.ALUop       = ctrl_q.aluop;
  assign bus.sximm8      = sximm8_q;
  assign bus.sximm5      = sximm5_q;

endmodule
